// File: rtl/alu_pkg.sv
// Shared ALU definitions: default datapath width and NZCV flag bit positions.
package alu_pkg;

   localparam int unsigned ALU_WIDTH = 32;

   localparam int unsigned FLAG_N = 3;
   localparam int unsigned FLAG_Z = 2;
   localparam int unsigned FLAG_C = 1;
   localparam int unsigned FLAG_V = 0;

   typedef logic [3:0] flags_t;

endpackage

// File: rtl/alu_flag_calc.sv
// Combinational NZCV flag derivation from adder sum, carry-out and carry into MSB.
// C is the raw carry-out (for subtract done as a+~b+1, C=1 means no borrow).
module alu_flag_calc
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = ALU_WIDTH
) (
   input  logic [WIDTH-1:0] sum,
   input  logic             co,
   input  logic             co_prev,
   output flags_t           flags
);

   // Assemble flags from the adder outputs
   always_comb begin
      flags         = '0;
      flags[FLAG_N] = sum[WIDTH-1];
      flags[FLAG_Z] = (sum == '0);
      flags[FLAG_C] = co;
      flags[FLAG_V] = co ^ co_prev;
   end

endmodule

// File: rtl/alu32_flag_stage.sv
// Registered result/flag stage behind the 32-bit adder: derives NZCV, buffers
// results in a 2-entry FIFO (valid/ready both sides) and keeps a sticky overflow.
// Optional macro ALU_FLAG_OVCNT_EN adds a saturating overflow event counter
// (ov_count), cleared by clr_sticky.
module alu32_flag_stage
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = ALU_WIDTH,
   parameter int unsigned DEPTH = 2,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] sum,
   input  logic             co_prev,
   input  logic             co,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       flags,
   output logic             sticky_ov,
`ifdef ALU_FLAG_OVCNT_EN
   output logic [CNT_W-1:0] ov_count,
`endif
   input  logic             clr_sticky
);

   if (DEPTH != 2) begin : g_bad_depth
      $error("alu32_flag_stage: DEPTH must be 2");
   end
   if (CNT_W < 1) begin : g_bad_cnt_w
      $error("alu32_flag_stage: CNT_W must be at least 1");
   end

   flags_t           new_flags;
   logic             push;
   logic             pop;
   logic [1:0]       count;
   logic             wr_ptr;
   logic             rd_ptr;
   logic [WIDTH-1:0] data_q [2];
   flags_t           flg_q  [2];

   alu_flag_calc #(.WIDTH(WIDTH)) u_flag_calc (
      .sum     (sum),
      .co      (co),
      .co_prev (co_prev),
      .flags   (new_flags)
   );

   // Handshake decode; in_ready depends on occupancy only
   always_comb begin
      in_ready  = (count < 2'd2);
      out_valid = (count != 2'd0);
      push      = in_valid & in_ready;
      pop       = out_valid & out_ready;
   end

   // Head entry drives the outputs; masked to zero while empty
   always_comb begin
      result = '0;
      flags  = '0;
      if (out_valid) begin
         result = data_q[rd_ptr];
         flags  = flg_q[rd_ptr];
      end
   end

   // Entry storage; no reset needed since outputs are masked when empty
   always_ff @(posedge clk) begin
      if (push) begin
         data_q[wr_ptr] <= sum;
         flg_q[wr_ptr]  <= new_flags;
      end
   end

   // Occupancy and 1-bit pointers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count  <= 2'd0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
      end else begin
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
         wr_ptr <= wr_ptr ^ push;
         rd_ptr <= rd_ptr ^ pop;
      end
   end

   // Sticky overflow: a new overflow beats a simultaneous clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sticky_ov <= 1'b0;
      end else if (push && new_flags[FLAG_V]) begin
         sticky_ov <= 1'b1;
      end else if (clr_sticky) begin
         sticky_ov <= 1'b0;
      end
   end

`ifdef ALU_FLAG_OVCNT_EN
   // Saturating overflow event counter: clear beats increment
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ov_count <= '0;
      end else if (clr_sticky) begin
         ov_count <= '0;
      end else if (push && new_flags[FLAG_V] && !(&ov_count)) begin
         ov_count <= ov_count + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_alu32_flag_stage.sv
// Self-checking bench for alu32_flag_stage: table-driven flag vectors plus
// hand-written backpressure, sticky and mid-stream reset sequences, with a
// scoreboard queue checking every popped result/flag pair in order.
module tb_alu32_flag_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] sum;
   logic        co_prev;
   logic        co;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic [3:0]  flags;
   logic        sticky_ov;
   logic        clr_sticky;
`ifdef ALU_FLAG_OVCNT_EN
   logic [15:0] ov_count;
`endif

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [31:0] res;
      logic [3:0]  flg;
   } exp_t;

   typedef struct {
      logic [31:0] sum;
      logic        co;
      logic        co_prev;
      logic [3:0]  exp_flags;
      logic        exp_sticky;
   } vec_t;

   exp_t       sb [$];
   logic [3:0] cur_exp;

   alu32_flag_stage #(.WIDTH(32), .DEPTH(2), .CNT_W(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .sum        (sum),
      .co_prev    (co_prev),
      .co         (co),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .result     (result),
      .flags      (flags),
      .sticky_ov  (sticky_ov),
`ifdef ALU_FLAG_OVCNT_EN
      .ov_count   (ov_count),
`endif
      .clr_sticky (clr_sticky)
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] model_flags(logic [31:0] s, logic c, logic cp);
      return {s[31], s == 32'd0, c, c ^ cp};
   endfunction

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic drive(logic [31:0] s, logic c, logic cp);
      sum      = s;
      co       = c;
      co_prev  = cp;
      cur_exp  = model_flags(s, c, cp);
      in_valid = 1'b1;
   endtask

   // Scoreboard: compare pops against queue head, then record pushes
   always @(negedge clk) begin
      if (!rst) begin
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               check("sb_unexpected_pop", {28'd0, flags, result}, 64'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("sb_result", {32'd0, result}, {32'd0, e.res});
               check("sb_flags", {60'd0, flags}, {60'd0, e.flg});
            end
         end
         if (in_valid && in_ready) sb.push_back('{res: sum, flg: cur_exp});
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs [8];
      vecs[0] = '{32'h8000_0000, 1'b0, 1'b1, 4'b1001, 1'b1};
      vecs[1] = '{32'h0000_0000, 1'b1, 1'b1, 4'b0110, 1'b1};
      vecs[2] = '{32'h0000_0001, 1'b0, 1'b0, 4'b0000, 1'b1};
      vecs[3] = '{32'hFFFF_FFFF, 1'b0, 1'b0, 4'b1000, 1'b1};
      vecs[4] = '{32'h7FFF_FFFE, 1'b1, 1'b0, 4'b0011, 1'b1};
      vecs[5] = '{32'h0000_0000, 1'b1, 1'b0, 4'b0111, 1'b1};
      vecs[6] = '{32'h8000_0000, 1'b1, 1'b1, 4'b1010, 1'b1};
      vecs[7] = '{32'h1234_5678, 1'b0, 1'b0, 4'b0000, 1'b1};

      rst = 1'b1; in_valid = 1'b0; sum = '0; co = 1'b0; co_prev = 1'b0;
      out_ready = 1'b0; clr_sticky = 1'b0; cur_exp = '0;
      #2;
      check("rst_out_valid", {63'd0, out_valid}, 64'd0);
      check("rst_in_ready", {63'd0, in_ready}, 64'd1);
      check("rst_result", {32'd0, result}, 64'd0);
      check("rst_flags", {60'd0, flags}, 64'd0);
      check("rst_sticky", {63'd0, sticky_ov}, 64'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

      // Flag table: one push per cycle with out_ready high
      out_ready = 1'b1;
      for (int unsigned i = 0; i < 8; i++) begin
         drive(vecs[i].sum, vecs[i].co, vecs[i].co_prev);
         cur_exp = vecs[i].exp_flags;
         @(posedge clk); #1;
         check("tbl_out_valid", {63'd0, out_valid}, 64'd1);
         check("tbl_result", {32'd0, result}, {32'd0, vecs[i].sum});
         check("tbl_flags", {60'd0, flags}, {60'd0, vecs[i].exp_flags});
         check("tbl_sticky", {63'd0, sticky_ov}, {63'd0, vecs[i].exp_sticky});
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
      check("empty_out_valid", {63'd0, out_valid}, 64'd0);
      check("empty_result", {32'd0, result}, 64'd0);
      check("empty_flags", {60'd0, flags}, 64'd0);
`ifdef ALU_FLAG_OVCNT_EN
      check("ov_count_tbl", {48'd0, ov_count}, 64'd3);
`endif

      // Sticky: clear alone, then set+clear together, then clear alone
      clr_sticky = 1'b1;
      @(posedge clk); #1;
      check("sticky_clr", {63'd0, sticky_ov}, 64'd0);
      drive(32'h8000_0000, 1'b0, 1'b1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("sticky_set_wins", {63'd0, sticky_ov}, 64'd1);
`ifdef ALU_FLAG_OVCNT_EN
      check("ov_count_clr_wins", {48'd0, ov_count}, 64'd0);
`endif
      @(posedge clk); #1;
      clr_sticky = 1'b0;
      check("sticky_clr2", {63'd0, sticky_ov}, 64'd0);
      check("drain_out_valid", {63'd0, out_valid}, 64'd0);

      // Backpressure: three back-to-back entries with out_ready low
      out_ready = 1'b0;
      drive(32'h0000_00A1, 1'b0, 1'b0);
      @(posedge clk); #1;
      drive(32'hFFFF_FFB2, 1'b1, 1'b1);
      @(posedge clk); #1;
      drive(32'h8000_00C3, 1'b1, 1'b0);
      check("full_in_ready", {63'd0, in_ready}, 64'd0);
      check("full_head", {32'd0, result}, 64'h0000_00A1);
      repeat (2) @(posedge clk);
      #1;
      check("full_hold_in_ready", {63'd0, in_ready}, 64'd0);
      check("full_hold_head", {32'd0, result}, 64'h0000_00A1);
      out_ready = 1'b1;
      begin
         int n = 0;
         @(negedge clk);
         while (!in_ready && n < 10) begin
            @(negedge clk);
            n++;
         end
         check("accept_timeout", {63'd0, in_ready}, 64'd1);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("pushpop_out_valid", {63'd0, out_valid}, 64'd1);
      check("pushpop_head", {32'd0, result}, 64'h8000_00C3);
      check("pushpop_flags", {60'd0, flags}, 64'b1011);
      @(posedge clk); #1;
      check("bp_drained", {63'd0, out_valid}, 64'd0);
      check("bp_sb_empty", {32'd0, sb.size()}, 64'd0);

      // Asynchronous reset with two entries held
      out_ready = 1'b0;
      drive(32'h0000_0D01, 1'b0, 1'b0);
      @(posedge clk); #1;
      drive(32'h0000_0E02, 1'b1, 1'b0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("pre_rst_full", {63'd0, in_ready}, 64'd0);
      #3 rst = 1'b1;
      #1;
      check("arst_out_valid", {63'd0, out_valid}, 64'd0);
      check("arst_result", {32'd0, result}, 64'd0);
      check("arst_flags", {60'd0, flags}, 64'd0);
      check("arst_in_ready", {63'd0, in_ready}, 64'd1);
      check("arst_sticky", {63'd0, sticky_ov}, 64'd0);
      sb.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      check("after_rst_out_valid", {63'd0, out_valid}, 64'd0);
      check("after_rst_in_ready", {63'd0, in_ready}, 64'd1);
      check("final_sb_empty", {32'd0, sb.size()}, 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
